// File: rtl/rf_writeback_buffer_pkg.sv
// Shared types and default widths for the register-file writeback path.
// The entry struct is the common result format used by the execute and memory stages.
package rf_writeback_buffer_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 4;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] rdst;
        logic [DEF_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic wb_entry_t make_entry(input logic [DEF_ADDR_W-1:0] rdst,
                                             input logic [DEF_DATA_W-1:0] data);
        wb_entry_t e;
        e.rdst = rdst;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/rf_writeback_buffer_if.sv
// Result handshake between the execute/memory stages (master) and the writeback buffer (slave).
interface rf_writeback_buffer_if
    import rf_writeback_buffer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_rdst;
    logic [DATA_W-1:0] wb_data;

    modport master (output wb_valid, output wb_rdst, output wb_data, input wb_ready);
    modport slave  (input wb_valid, input wb_rdst, input wb_data, output wb_ready);
endinterface

// File: rtl/rf_writeback_buffer_fwd_match.sv
// Youngest-match search over the occupied FIFO slots, walked in age order from the head.
// Slots beyond the occupied count never match, so stale entries cannot forward.
module rf_fwd_match #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [$clog2(DEPTH):0]   occupied,
    input  logic [ADDR_W-1:0]        key,
    input  logic [ADDR_W-1:0]        rdst_arr [DEPTH],
    input  logic [DATA_W-1:0]        data_arr [DEPTH],
    output logic                     hit,
    output logic [DATA_W-1:0]        data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // match[k] refers to the k-th oldest entry, not to physical slot k
    logic [DEPTH-1:0] match;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        logic [PTR_W-1:0] slot;
        assign slot      = head + PTR_W'(gi);
        assign match[gi] = (CNT_W'(gi) < occupied) && (rdst_arr[slot] == key);
    end

    always_comb begin
        hit  = |match;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
                data = data_arr[head + PTR_W'(i)];
            end
        end
    end
endmodule

// File: rtl/rf_writeback_buffer.sv
// In-order writeback FIFO feeding the register-file write port, with
// bypass lookups so operand reads see results that are still queued.
module rf_writeback_buffer
    import rf_writeback_buffer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rf_writeback_buffer_if.slave   wb,
    input  logic                   rf_wr_hold,
    output logic                   rf_wr_en,
    output logic [ADDR_W-1:0]      rf_wr_addr,
    output logic [DATA_W-1:0]      rf_wr_data,
    input  logic [ADDR_W-1:0]      rsrc1,
    input  logic [ADDR_W-1:0]      rsrc2,
    output logic                   fwd1_hit,
    output logic [DATA_W-1:0]      fwd1_data,
    output logic                   fwd2_hit,
    output logic [DATA_W-1:0]      fwd2_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]  head_reg, tail_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [ADDR_W-1:0] rdst_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              enq, deq, full;
    logic [CNT_W-1:0]  occupied;

    // Full is judged on registered count only; a same-cycle dequeue does not free a slot early
    assign full        = (count_reg == CNT_W'(DEPTH));
    assign wb.wb_ready = rst_n && !full;
    assign rf_wr_en    = rst_n && (count_reg != '0) && !rf_wr_hold;
    assign enq         = wb.wb_valid && wb.wb_ready;
    assign deq         = rf_wr_en;

    assign rf_wr_addr  = rf_wr_en ? rdst_mem[head_reg] : '0;
    assign rf_wr_data  = rf_wr_en ? data_mem[head_reg] : '0;
    assign count       = count_reg;
    assign occupied    = rst_n ? count_reg : '0;

    always_comb begin
        count_next = count_reg + CNT_W'(enq) - CNT_W'(deq);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_reg + PTR_W'(deq);
            tail_reg  <= tail_reg + PTR_W'(enq);
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            rdst_mem[tail_reg] <= wb.wb_rdst;
            data_mem[tail_reg] <= wb.wb_data;
        end
    end

    rf_fwd_match #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd1 (
        .head     (head_reg),
        .occupied (occupied),
        .key      (rsrc1),
        .rdst_arr (rdst_mem),
        .data_arr (data_mem),
        .hit      (fwd1_hit),
        .data     (fwd1_data)
    );

    rf_fwd_match #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fwd2 (
        .head     (head_reg),
        .occupied (occupied),
        .key      (rsrc2),
        .rdst_arr (rdst_mem),
        .data_arr (data_mem),
        .hit      (fwd2_hit),
        .data     (fwd2_data)
    );
endmodule

// File: tb/tb_rf_writeback_buffer.sv
// Directed bench for rf_writeback_buffer: a queue scoreboard predicts writes, count,
// handshake and bypass results every cycle; directed checks cover the key scenarios.
module tb_rf_writeback_buffer;
    import rf_writeback_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rf_wr_hold = 1'b0;
    logic [4:0]  rsrc1 = '0, rsrc2 = '0;
    logic        rf_wr_en, fwd1_hit, fwd2_hit;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data, fwd1_data, fwd2_data;
    logic [2:0]  count;

    rf_writeback_buffer_if wbi ();

    always #5 clk = ~clk;

    rf_writeback_buffer #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb         (wbi.slave),
        .rf_wr_hold (rf_wr_hold),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .rsrc1      (rsrc1),
        .rsrc2      (rsrc2),
        .fwd1_hit   (fwd1_hit),
        .fwd1_data  (fwd1_data),
        .fwd2_hit   (fwd2_hit),
        .fwd2_data  (fwd2_data),
        .count      (count)
    );

    int        checks = 0;
    int        errors = 0;
    int        writes = 0;
    wb_entry_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [4:0] key, output logic hit, output logic [31:0] val);
        hit = 1'b0;
        val = '0;
        foreach (sb[i]) begin
            if (sb[i].rdst == key) begin
                hit = 1'b1;
                val = sb[i].data;
            end
        end
    endtask

    // One clock: check everything at the falling edge, update the model, return #1 after the rising edge
    task automatic step();
        logic        h;
        logic [31:0] v;
        logic        exp_ready, exp_en;
        @(negedge clk);
        exp_ready = rst_n && (sb.size() < DEPTH);
        exp_en    = rst_n && (sb.size() != 0) && !rf_wr_hold;
        check("count", 64'(count), 64'(sb.size()));
        check("wb_ready", 64'(wbi.wb_ready), 64'(exp_ready));
        check("rf_wr_en", 64'(rf_wr_en), 64'(exp_en));
        lookup(rsrc1, h, v);
        if (!rst_n) h = 1'b0;
        check("fwd1_hit", 64'(fwd1_hit), 64'(h));
        if (h) check("fwd1_data", 64'(fwd1_data), 64'(v));
        lookup(rsrc2, h, v);
        if (!rst_n) h = 1'b0;
        check("fwd2_hit", 64'(fwd2_hit), 64'(h));
        if (h) check("fwd2_data", 64'(fwd2_data), 64'(v));
        if (exp_en) begin
            check("wr_addr", 64'(rf_wr_addr), 64'(sb[0].rdst));
            check("wr_data", 64'(rf_wr_data), 64'(sb[0].data));
            $display("WRITE #%0d r%0d <= %08h (expected r%0d <= %08h)",
                     writes, rf_wr_addr, rf_wr_data, sb[0].rdst, sb[0].data);
            void'(sb.pop_front());
            writes++;
        end
        if (!rst_n) sb.delete();
        else if (wbi.wb_valid && exp_ready) sb.push_back(make_entry(wbi.wb_rdst, wbi.wb_data));
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] r, input logic [31:0] d);
        wbi.wb_valid = 1'b1;
        wbi.wb_rdst  = r;
        wbi.wb_data  = d;
        step();
        wbi.wb_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (sb.size() == 0) break;
            step();
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    int writes_before;

    initial begin
        wbi.wb_valid = 1'b0;
        wbi.wb_rdst  = '0;
        wbi.wb_data  = '0;

        // reset state
        step();
        step();
        check("rst_count", 64'(count), 64'd0);

        // single result: accepted at edge N, written at edge N+1
        rst_n = 1'b1;
        offer(5'd5, 32'hDEADBEEF);
        check("lat_count", 64'(count), 64'd1);
        check("lat_en", 64'(rf_wr_en), 64'd1);
        check("lat_addr", 64'(rf_wr_addr), 64'd5);
        check("lat_data", 64'(rf_wr_data), 64'hDEADBEEF);
        step();
        check("lat_count_after", 64'(count), 64'd0);

        // fill to full under hold, fifth offer waits, release drains in order
        rf_wr_hold = 1'b1;
        for (int i = 1; i <= 4; i++) offer(5'(i), 32'h100 + 32'(i));
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(wbi.wb_ready), 64'd0);
        wbi.wb_valid = 1'b1;
        wbi.wb_rdst  = 5'd9;
        wbi.wb_data  = 32'h999;
        step();
        check("full_not_consumed", 64'(count), 64'd4);
        rf_wr_hold = 1'b0;
        step();
        check("ready_after_deq", 64'(wbi.wb_ready), 64'd1);
        step();
        wbi.wb_valid = 1'b0;
        drain();

        // bypass returns youngest of two pending writes to the same register
        rf_wr_hold = 1'b1;
        offer(5'd7, 32'd10);
        offer(5'd7, 32'd20);
        rsrc1 = 5'd7;
        rsrc2 = 5'd3;
        #1;
        check("byp_hit1", 64'(fwd1_hit), 64'd1);
        check("byp_data1", 64'(fwd1_data), 64'd20);
        check("byp_hit2", 64'(fwd2_hit), 64'd0);
        rsrc2 = 5'd7;
        #1;
        check("byp_same_hit", 64'(fwd2_hit), 64'd1);
        check("byp_same_data", 64'(fwd2_data), 64'd20);
        step();
        rf_wr_hold = 1'b0;
        drain();
        rsrc1 = '0;
        rsrc2 = '0;

        // simultaneous enqueue/dequeue at count=2 across pointer wrap, register 0 included
        rf_wr_hold = 1'b1;
        offer(5'd11, 32'hB000_0011);
        offer(5'd12, 32'hB000_0012);
        rf_wr_hold = 1'b0;
        for (int i = 0; i < 12; i++) begin
            wbi.wb_valid = 1'b1;
            wbi.wb_rdst  = 5'(i * 3);
            wbi.wb_data  = 32'hA000_0000 + 32'(i);
            rsrc1        = 5'(i * 3);
            step();
            check("simul_count", 64'(count), 64'd2);
        end
        wbi.wb_valid = 1'b0;
        drain();

        // reset mid-operation discards pending entries
        rf_wr_hold = 1'b1;
        offer(5'd21, 32'hC021);
        offer(5'd22, 32'hC022);
        offer(5'd23, 32'hC023);
        check("mid_count", 64'(count), 64'd3);
        rsrc1 = 5'd22;
        rsrc2 = 5'd23;
        writes_before = writes;
        rst_n = 1'b0;
        rf_wr_hold = 1'b0;
        #1;
        check("mid_rst_en", 64'(rf_wr_en), 64'd0);
        step();
        check("mid_rst_count", 64'(count), 64'd0);
        rst_n = 1'b1;
        #1;
        check("mid_fwd1", 64'(fwd1_hit), 64'd0);
        check("mid_fwd2", 64'(fwd2_hit), 64'd0);
        step();
        step();
        step();
        check("mid_no_writes", 64'(writes), 64'(writes_before));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rf_writeback_buffer.md
Name: rf_writeback_buffer

Overview:
- Producer side of the register-file write port.
- Accepts completed results (destination index plus 32-bit value) from the execute/memory stages over a valid/ready handshake.
- Holds them in a small in-order FIFO and drives the register-file write port (write enable, address, data) one entry per cycle.
- Gives the operand-read path a bypass lookup, so reads of a register with a pending write return the pending value instead of the stale one.

Parameters:
- DATA_W, 32, width of a register value.
- ADDR_W, 5, width of a register index (32 registers).
- DEPTH, 4, number of FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- wb_valid  in  1  producer has a result this cycle.
- wb_ready  out  1  buffer can accept a result this cycle.
- wb_rdst  in  ADDR_W  destination register index of the offered result.
- wb_data  in  DATA_W  offered result value.
- rf_wr_hold  in  1  register-file write port unavailable this cycle.
- rf_wr_en  out  1  write strobe to the register file (its RF_WRITE).
- rf_wr_addr  out  ADDR_W  write address (its MuxC_Out_Rdst).
- rf_wr_data  out  DATA_W  write data (its RY).
- rsrc1  in  ADDR_W  operand-1 read index, also driven to the register file.
- rsrc2  in  ADDR_W  operand-2 read index.
- fwd1_hit  out  1  a pending entry targets rsrc1.
- fwd1_data  out  DATA_W  value of the youngest pending entry targeting rsrc1.
- fwd2_hit  out  1  a pending entry targets rsrc2.
- fwd2_data  out  DATA_W  value of the youngest pending entry targeting rsrc2.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
Reset and acceptance:
- Reset: any rising edge with rst_n=0 sets head pointer, tail pointer and count to 0 and discards pending entries. No register-file write is issued on that edge.
- While rst_n=0, force wb_ready=0, rf_wr_en=0, fwd1_hit=0 and fwd2_hit=0. Data outputs are don't-care when their qualifier is 0 (drive 0).
- wb_ready = rst_n AND (count < DEPTH). It is combinational from state only, never from wb_valid.
- Enqueue on an edge where wb_valid AND wb_ready: write {wb_rdst, wb_data} at the tail, then advance the tail pointer modulo DEPTH.
- wb_valid while wb_ready=0 is not consumed. The producer holds its inputs stable.
- Full is strict: at count=DEPTH, wb_ready=0 even if a dequeue happens that cycle.

Write port and dequeue:
- rf_wr_en = rst_n AND (count != 0) AND NOT rf_wr_hold.
- rf_wr_addr and rf_wr_data are combinational from the head entry.
- Dequeue on every edge where rf_wr_en=1: the register file captures the write on that same edge, and the head pointer advances modulo DEPTH.
- count next = count + enq - deq. Simultaneous enqueue and dequeue leaves count unchanged.
- Latency: a result accepted at edge N is written to the register file at edge N+1 at the earliest (empty buffer, no hold). Each entry queued ahead of it, and each hold cycle, adds one edge.
- Ordering: strictly in order. Two pending writes to the same register both reach the register file, oldest first.
- Register index 0 is not special; it is written like any other.
- Pointer wrap: pointers carry no extra bit; full/empty come from count only.

Bypass lookup:
- Combinational over the occupied entries only (head through tail-1). The incoming wb_* result is not searched.
- fwdN_hit=1 if any occupied entry has rdst == rsrcN.
- fwdN_data is the value of the youngest matching entry (closest to the tail).
- The head entry being written this cycle still counts as pending and can hit.
- rsrc1 == rsrc2 yields identical fwd1 and fwd2 outputs.

Decomposition:
- Shared package: DATA_W and ADDR_W defaults, plus a packed wb_entry struct {rdst, data} reused by the execute and memory stages.
- One natural sub-module, rf_fwd_match: a youngest-match priority search over the entry array. Instantiate it twice, once per read port.

Test Plan:
- After reset: offer rdst=5, data=32'hDEADBEEF with the buffer empty -> wb_ready=1, accepted at edge N. Next cycle count=1, rf_wr_en=1, addr=5, data=DEADBEEF. Count returns to 0 after edge N+1.
- Fill to full: hold rf_wr_hold=1 and offer 4 results (r1..r4 = 1,2,3,4) -> count=4, wb_ready=0. A fifth offer is not consumed. Release hold -> writes r1..r4 on four consecutive edges, in order; wb_ready reasserts after the first dequeue.
- Bypass youngest: with hold=1, queue r7=10 then r7=20; set rsrc1=7, rsrc2=3 -> fwd1_hit=1, fwd1_data=20, fwd2_hit=0.
- Simultaneous enqueue and dequeue at count=2 -> count stays 2. Writes appear in acceptance order across pointer wrap over 10 or more results.
- Reset mid-operation: count=3, assert rst_n=0 for one edge -> count=0, rf_wr_en=0, no write on that edge, pending entries never written, and fwd hits are 0 after release.
